trigger_sequencer: RTL

//  Arms, gates and rate-limits the trigger chain between digital_edge_detector and delay_module.

---
 rtl/trigger_sequencer_if.sv | 40 ++++
 rtl/trigger_sequencer.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/trigger_sequencer_if.sv
// rtl/trigger_sequencer_if.sv - register bus and trigger chain signals of trigger_sequencer
//
// Groups the cmd_handler register bus and the trigger chain handshakes.
//   master : host / upstream side (drives commands, trigger_in, trigger_busy)
//   slave  : trigger_sequencer side (drives read data, trigger_fire, armed, done)
// Signals:
//   reg_cmd[7:0]        command/address from cmd_handler
//   reg_bytecount[15:0] byte index within current command
//   reg_data_in[7:0]    write data byte
//   reg_data_out[7:0]   registered read data, 8'h00 unless reg_cmd selects STATUS
//   reg_read/reg_write  one-cycle strobes
//   trigger_in          one-cycle edge pulse from the edge detector
//   trigger_busy        downstream delay/extender still processing
//   trigger_fire        one-cycle qualified trigger to delay_module
//   armed/done          state indicators
interface trigger_sequencer_if;
    logic [7:0]  reg_cmd;
    logic [15:0] reg_bytecount;
    logic [7:0]  reg_data_in;
    logic [7:0]  reg_data_out;
    logic        reg_read;
    logic        reg_write;
    logic        trigger_in;
    logic        trigger_busy;
    logic        trigger_fire;
    logic        armed;
    logic        done;

    modport master (
        output reg_cmd, reg_bytecount, reg_data_in, reg_read, reg_write,
        output trigger_in, trigger_busy,
        input  reg_data_out, trigger_fire, armed, done
    );

    modport slave (
        input  reg_cmd, reg_bytecount, reg_data_in, reg_read, reg_write,
        input  trigger_in, trigger_busy,
        output reg_data_out, trigger_fire, armed, done
    );
endinterface

// File: rtl/trigger_sequencer.sv
// rtl/trigger_sequencer.sv - arms, gates and rate-limits the trigger chain
//
// Passes at most target qualified trigger_in pulses to trigger_fire, with a
// programmable holdoff after each fire. Configured over the register bus.
// Ports:
//   clkin  : sole clock
//   reset  : synchronous, active-low reset
//   bus    : trigger_sequencer_if.slave (register bus + trigger chain)
module trigger_sequencer #(
    parameter logic [7:0] ADDR_CTRL    = 8'h10,
    parameter logic [7:0] ADDR_COUNT   = 8'h11,
    parameter logic [7:0] ADDR_HOLDOFF = 8'h12,
    parameter logic [7:0] ADDR_STATUS  = 8'h13
) (
    input  logic                  clkin,
    input  logic                  reset,
    trigger_sequencer_if.slave    bus
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARMED   = 3'd1,
        S_FIRE    = 3'd2,
        S_HOLDOFF = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] target_q, target_d;
    logic [15:0] holdoff_q, holdoff_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] fired_q, fired_d;
    logic [7:0]  missed_q, missed_d;
    logic [7:0]  rd_data_q, rd_data_d;

    logic        ctrl_wr;
    logic        arm_req;
    logic        disarm_req;
    logic        count_wr;
    logic        holdoff_wr;
    logic [15:0] fired_inc;
    logic [7:0]  missed_inc;
    logic [7:0]  status_byte;

    // Control bits live in byte0 only; COUNT/HOLDOFF only take bytes 0 and 1.
    assign ctrl_wr    = bus.reg_write && (bus.reg_cmd == ADDR_CTRL) && (bus.reg_bytecount == 16'd0);
    assign arm_req    = ctrl_wr && bus.reg_data_in[0];
    assign disarm_req = ctrl_wr && bus.reg_data_in[1];
    assign count_wr   = bus.reg_write && (bus.reg_cmd == ADDR_COUNT) && (bus.reg_bytecount <= 16'd1);
    assign holdoff_wr = bus.reg_write && (bus.reg_cmd == ADDR_HOLDOFF) && (bus.reg_bytecount <= 16'd1);

    assign fired_inc  = fired_q + 16'd1;
    // missed saturates rather than wrapping so a flood of busy rejections stays visible
    assign missed_inc = (missed_q == 8'hFF) ? missed_q : missed_q + 8'd1;

    always_comb begin
        status_byte = 8'h00;
        case (bus.reg_bytecount)
            16'd0:   status_byte = {3'b000, bus.armed, bus.done, state_q};
            16'd1:   status_byte = fired_q[7:0];
            16'd2:   status_byte = fired_q[15:8];
            16'd3:   status_byte = missed_q;
            default: status_byte = 8'h00;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        target_d  = target_q;
        holdoff_d = holdoff_q;
        cnt_d     = cnt_q;
        fired_d   = fired_q;
        missed_d  = missed_q;
        rd_data_d = rd_data_q;

        if (count_wr) begin
            if (bus.reg_bytecount[0]) target_d[15:8] = bus.reg_data_in;
            else                      target_d[7:0]  = bus.reg_data_in;
        end
        if (holdoff_wr) begin
            if (bus.reg_bytecount[0]) holdoff_d[15:8] = bus.reg_data_in;
            else                      holdoff_d[7:0]  = bus.reg_data_in;
        end

        if (bus.reg_read) begin
            rd_data_d = (bus.reg_cmd == ADDR_STATUS) ? status_byte : 8'h00;
        end

        // DISARM takes priority over everything else in the same cycle.
        if (disarm_req) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (arm_req) begin
                        state_d  = S_ARMED;
                        fired_d  = 16'd0;
                        missed_d = 8'd0;
                    end
                end
                S_ARMED: begin
                    if (bus.trigger_in) begin
                        if (!bus.trigger_busy) state_d  = S_FIRE;
                        else                   missed_d = missed_inc;
                    end
                end
                S_FIRE: begin
                    fired_d = fired_inc;
                    if ((target_q != 16'd0) && (fired_inc == target_q)) begin
                        state_d = S_DONE;
                    end else if (holdoff_q == 16'd0) begin
                        state_d = S_ARMED;
                    end else begin
                        state_d = S_HOLDOFF;
                        cnt_d   = holdoff_q;
                    end
                end
                S_HOLDOFF: begin
                    cnt_d = cnt_q - 16'd1;
                    // cnt is never 0 here; <= guards against a stuck state anyway
                    if (cnt_q <= 16'd1) state_d = S_ARMED;
                    if (bus.trigger_in) missed_d = missed_inc;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clkin) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            target_q  <= 16'd0;
            holdoff_q <= 16'd0;
            cnt_q     <= 16'd0;
            fired_q   <= 16'd0;
            missed_q  <= 8'd0;
            rd_data_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            target_q  <= target_d;
            holdoff_q <= holdoff_d;
            cnt_q     <= cnt_d;
            fired_q   <= fired_d;
            missed_q  <= missed_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign bus.trigger_fire = (state_q == S_FIRE);
    assign bus.armed        = (state_q == S_ARMED);
    assign bus.done         = (state_q == S_DONE);
    // Shared OR'd return bus: only drive while STATUS is addressed.
    assign bus.reg_data_out = (bus.reg_cmd == ADDR_STATUS) ? rd_data_q : 8'h00;

endmodule
